// File: rtl/axis_sample_source_if.sv
// AXI4-Stream bundle for the 32-bit complex-sample link toward the AIE array.
// The master drives data/valid/last/keep/strb and the slave returns ready.
interface axis_sample_source_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [3:0]  tkeep;
  logic [3:0]  tstrb;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tkeep,
    output tstrb,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tkeep,
    input  tstrb,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_sample_source.sv
// Framed AXI4-Stream test-pattern source (ramp / LFSR / alternating full-scale).
// Outputs are fully registered; tvalid never depends on tready.
module axis_sample_source #(
  parameter int          LEN_W     = 16,
  parameter int          GAP_W     = 8,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic [LEN_W-1:0]     num_frames,
  input  logic [GAP_W-1:0]     gap_cycles,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     frames_sent,
  axis_sample_source_if.master m_axis
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Run configuration, captured once when a start is accepted
  logic [1:0]       r_mode;
  logic [LEN_W-1:0] r_len_m1;
  logic [LEN_W-1:0] r_num_frames;
  logic [GAP_W-1:0] r_gap;

  logic [31:0]      r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_busy;
  logic             r_done;
  logic [LEN_W-1:0] r_frames;
  logic [LEN_W-1:0] r_beat;
  logic [15:0]      r_n;
  logic [31:0]      r_lfsr;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_stop_pend;

  logic [31:0]      w_tdata_next;
  logic             w_tvalid_next;
  logic             w_tlast_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic [LEN_W-1:0] w_frames_next;
  logic [LEN_W-1:0] w_beat_next;
  logic [15:0]      w_n_next;
  logic [31:0]      w_lfsr_next;
  logic [GAP_W-1:0] w_gap_cnt_next;
  logic             w_stop_pend_next;

  logic             w_accept;
  logic             w_hs;
  logic             w_last_hs;
  logic             w_final;
  logic             w_first_last;
  logic [LEN_W-1:0] w_frames_inc;
  logic [LEN_W-1:0] w_beat_inc;
  logic [15:0]      w_n_inc;
  logic [31:0]      w_lfsr_adv;
  logic [31:0]      w_sample_cur;
  logic [31:0]      w_sample_nxt;

  function automatic logic [31:0] gen_sample(input logic [1:0]  m,
                                             input logic [15:0] n,
                                             input logic [31:0] lfsr);
    logic [31:0] s;
    case (m)
      2'd1:    s = lfsr;
      2'd2:    s = n[0] ? 32'h7FFF_8001 : 32'h8001_7FFF;
      default: s = {16'h0000 - n, n};
    endcase
    return s;
  endfunction

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_hs         = r_tvalid && m_axis.tready;
  assign w_last_hs    = w_hs && r_tlast;
  assign w_frames_inc = r_frames + LEN_ONE;
  assign w_beat_inc   = r_beat + LEN_ONE;
  assign w_n_inc      = r_n + 16'd1;
  assign w_first_last = (r_len_m1 == '0);
  // A stop arriving on the closing handshake itself still ends the run here
  assign w_final      = ((r_num_frames != '0) && (w_frames_inc == r_num_frames))
                        || r_stop_pend || stop;

  // Fibonacci LFSR, taps 32,22,2,1
  assign w_lfsr_adv   = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_sample_cur = gen_sample(r_mode, r_n, r_lfsr);
  assign w_sample_nxt = gen_sample(r_mode, w_n_inc, w_lfsr_adv);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_LOAD;
      S_LOAD: w_state_next = S_SEND;
      S_SEND: begin
        if (w_last_hs) begin
          if (w_final)            w_state_next = S_IDLE;
          else if (r_gap == '0)   w_state_next = S_SEND;
          else                    w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (stop)                    w_state_next = S_IDLE;
        else if (r_gap_cnt == GAP_ONE) w_state_next = S_SEND;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tdata_next     = r_tdata;
    w_tvalid_next    = r_tvalid;
    w_tlast_next     = r_tlast;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_frames_next    = r_frames;
    w_beat_next      = r_beat;
    w_n_next         = r_n;
    w_lfsr_next      = r_lfsr;
    w_gap_cnt_next   = r_gap_cnt;
    w_stop_pend_next = r_stop_pend;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_next      = 1'b1;
          w_frames_next    = '0;
          w_beat_next      = '0;
          w_n_next         = 16'd0;
          w_lfsr_next      = LFSR_SEED;
          w_stop_pend_next = 1'b0;
        end
      end
      S_LOAD: begin
        w_stop_pend_next = r_stop_pend | stop;
        w_tvalid_next    = 1'b1;
        w_tdata_next     = w_sample_cur;
        w_tlast_next     = w_first_last;
      end
      S_SEND: begin
        w_stop_pend_next = r_stop_pend | stop;
        if (w_hs) begin
          w_n_next     = w_n_inc;
          w_lfsr_next  = w_lfsr_adv;
          w_tdata_next = w_sample_nxt;
          if (r_tlast) begin
            w_frames_next    = w_frames_inc;
            w_beat_next      = '0;
            w_stop_pend_next = 1'b0;
            w_tlast_next     = w_first_last;
            if (w_final) begin
              w_tvalid_next = 1'b0;
              w_tlast_next  = 1'b0;
              w_busy_next   = 1'b0;
              w_done_next   = 1'b1;
            end else if (r_gap != '0) begin
              w_tvalid_next  = 1'b0;
              w_gap_cnt_next = r_gap;
            end
          end else begin
            w_beat_next  = w_beat_inc;
            w_tlast_next = (w_beat_inc == r_len_m1);
          end
        end
      end
      S_GAP: begin
        w_gap_cnt_next = r_gap_cnt - GAP_ONE;
        if (stop) begin
          w_tlast_next = 1'b0;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end else if (r_gap_cnt == GAP_ONE) begin
          // Sample index and LFSR already advanced on the closing handshake
          w_tvalid_next = 1'b1;
          w_tdata_next  = w_sample_cur;
          w_tlast_next  = w_first_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_tdata     <= 32'h0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frames    <= '0;
      r_beat      <= '0;
      r_n         <= 16'd0;
      r_lfsr      <= LFSR_SEED;
      r_gap_cnt   <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_tdata     <= w_tdata_next;
      r_tvalid    <= w_tvalid_next;
      r_tlast     <= w_tlast_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_frames    <= w_frames_next;
      r_beat      <= w_beat_next;
      r_n         <= w_n_next;
      r_lfsr      <= w_lfsr_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_stop_pend <= w_stop_pend_next;
    end
  end

  // Zero frame length is stored as length one so tlast compares stay simple
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_mode       <= 2'd0;
      r_len_m1     <= '0;
      r_num_frames <= '0;
      r_gap        <= '0;
    end else if (w_accept) begin
      r_mode       <= mode;
      r_len_m1     <= (frame_len == '0) ? '0 : (frame_len - LEN_ONE);
      r_num_frames <= num_frames;
      r_gap        <= gap_cycles;
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tkeep  = 4'hF;
  assign m_axis.tstrb  = 4'hF;
  assign busy          = r_busy;
  assign done          = r_done;
  assign frames_sent   = r_frames;

endmodule

// File: tb/tb_axis_sample_source.sv
// Directed + randomized bench for axis_sample_source against a beat-list reference model.
// Every handshake is compared with the next expected {tlast, tdata} entry.
module tb_axis_sample_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] frame_len;
  logic [15:0] num_frames;
  logic [7:0]  gap_cycles;
  logic        busy;
  logic        done;
  logic [15:0] frames_sent;

  axis_sample_source_if axis();

  axis_sample_source #(
    .LEN_W(16),
    .GAP_W(8),
    .LFSR_SEED(32'h0000_0001)
  ) dut (
    .axis_aclk   (clk),
    .axis_aresetn(rst_n),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .frame_len   (frame_len),
    .num_frames  (num_frames),
    .gap_cycles  (gap_cycles),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent),
    .m_axis      (axis)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] ref_sample(input int m, input int k, input logic [31:0] st);
    logic [15:0] i_part;
    logic [15:0] q_part;
    i_part = 16'(k % 65536);
    q_part = 16'((65536 - (k % 65536)) % 65536);
    if (m == 1) return st;
    if (m == 2) return ((k % 2) == 0) ? 32'h8001_7FFF : 32'h7FFF_8001;
    return {q_part, i_part};
  endfunction

  // Full list of beats a run of `frames` frames should produce
  task automatic build_exp(input int m, input int len, input int frames);
    int le;
    logic [31:0] st;
    le = (len == 0) ? 1 : len;
    st = 32'h0000_0001;
    exp_q.delete();
    for (int k = 0; k < frames * le; k++) begin
      exp_q.push_back({((k % le) == (le - 1)) ? 1'b1 : 1'b0, ref_sample(m, k, st)});
      st = lfsr_step(st);
    end
  endtask

  task automatic launch(input int m, input int len, input int frames, input int gap);
    mode       = 2'(m);
    frame_len  = 16'(len);
    num_frames = 16'(frames);
    gap_cycles = 8'(gap);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    mode       = 2'($urandom_range(0, 3));
    frame_len  = 16'($urandom_range(0, 40));
    num_frames = 16'($urandom_range(0, 9));
    gap_cycles = 8'($urandom_range(0, 7));
  endtask

  // rdy_mode: 0 always ready, 1 toggling with a 5-cycle low burst, 2 random
  task automatic run_stream(input string name, input int rdy_mode, input int gap,
                            input int stop_beat, input int busy_start_c,
                            input int rst_beat, input int exp_frames);
    int c, beats, done_cnt, last_hs_c, low, post;
    bit wait_gap, first_seen, prev_v, prev_r, aborted;
    logic [31:0] prev_d, d;
    logic prev_l, v, l, r;
    logic [32:0] e;
    c = 1; beats = 0; done_cnt = 0; last_hs_c = -10; low = 0; post = -1;
    wait_gap = 0; first_seen = 0; prev_v = 0; prev_r = 0; aborted = 0;
    prev_d = 0; prev_l = 0;
    chk({name, " busy_after_start"}, 32'(busy), 32'd1);
    chk({name, " tvalid_in_load"}, 32'(axis.tvalid), 32'd0);
    while (c < 600 && post != 0) begin
      v = axis.tvalid; d = axis.tdata; l = axis.tlast;
      if (post > 0) post--;
      if (done) begin
        done_cnt++;
        chk({name, " done_latency"}, 32'(c), 32'(last_hs_c + 1));
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        if (post < 0) post = 3;
      end
      if (v && !first_seen) begin
        first_seen = 1;
        chk({name, " first_tvalid_latency"}, 32'(c), 32'd2);
      end
      if (prev_v && !prev_r) begin
        chk({name, " stall_tvalid"}, 32'(v), 32'd1);
        chk({name, " stall_tdata"}, d, prev_d);
        chk({name, " stall_tlast"}, 32'(l), 32'(prev_l));
      end
      if (wait_gap) begin
        if (!v) low++;
        else begin
          chk({name, " gap_cycles"}, 32'(low), 32'(gap));
          wait_gap = 0;
        end
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (c >= 10 && c <= 14) ? 1'b0 : ((c % 2) == 1);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      axis.tready = r;
      stop  = (v && beats == stop_beat);
      start = (c == busy_start_c);
      if (v && beats == rst_beat) begin
        #2 rst_n = 1'b0;
        #1;
        chk({name, " async_tvalid_drop"}, 32'(axis.tvalid), 32'd0);
        chk({name, " async_busy_drop"}, 32'(busy), 32'd0);
        aborted = 1;
        break;
      end
      if (v && r) begin
        if (exp_q.size() == 0) chk({name, " extra_beat"}, d, 32'hDEAD_BEEF);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("%s beat%0d_tdata", name, beats), d, e[31:0]);
          chk($sformatf("%s beat%0d_tlast", name, beats), 32'(l), 32'(e[32]));
        end
        beats++;
        if (l) begin
          last_hs_c = c;
          if (exp_q.size() != 0) begin wait_gap = 1; low = 0; end
        end
      end
      prev_v = v; prev_d = d; prev_l = l; prev_r = r;
      @(negedge clk);
      c++;
    end
    stop = 1'b0; start = 1'b0; axis.tready = 1'b0;
    if (aborted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk({name, " no_done_in_reset"}, 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk({name, " idle_after_reset"}, {30'd0, busy, axis.tvalid}, 32'd0);
      exp_q.delete();
    end else begin
      chk({name, " done_pulses"}, 32'(done_cnt), 32'd1);
      chk({name, " beats_missing"}, 32'(exp_q.size()), 32'd0);
      chk({name, " frames_sent"}, 32'(frames_sent), 32'(exp_frames));
      $display("run %s: beats=%0d frames_sent=%0d", name, beats, frames_sent);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int rm, rl, rf, rg;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    frame_len = 16'd0; num_frames = 16'd0; gap_cycles = 8'd0; axis.tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tvalid", 32'(axis.tvalid), 32'd0);
    chk("reset tdata", axis.tdata, 32'd0);
    chk("reset tlast", 32'(axis.tlast), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset frames_sent", 32'(frames_sent), 32'd0);
    chk("tkeep", 32'(axis.tkeep), 32'hF);
    chk("tstrb", 32'(axis.tstrb), 32'hF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    launch(0, 4, 2, 0); build_exp(0, 4, 2);
    run_stream("ramp", 0, 0, -1, -1, -1, 2);

    launch(0, 4, 2, 0); build_exp(0, 4, 2);
    run_stream("backpressure", 1, 0, -1, -1, -1, 2);

    launch(2, 0, 3, 3); build_exp(2, 0, 3);
    run_stream("gap_len0", 0, 3, -1, -1, -1, 3);

    launch(0, 16, 0, 0); build_exp(0, 16, 2);
    run_stream("stop", 0, 0, 20, 8, -1, 2);

    launch(1, 8, 1, 0); build_exp(1, 8, 1);
    run_stream("lfsr", 2, 0, -1, -1, -1, 1);

    for (int i = 0; i < 4; i++) begin
      rm = $urandom_range(0, 3); rl = $urandom_range(0, 5);
      rf = $urandom_range(1, 3); rg = $urandom_range(0, 3);
      launch(rm, rl, rf, rg); build_exp(rm, rl, rf);
      run_stream($sformatf("rand%0d_m%0d_l%0d_f%0d_g%0d", i, rm, rl, rf, rg), 2, rg, -1, -1, -1, rf);
    end

    launch(0, 8, 1, 0); build_exp(0, 8, 1);
    run_stream("reset_mid", 0, 0, -1, -1, 5, 1);

    launch(0, 4, 1, 0); build_exp(0, 4, 1);
    run_stream("after_reset", 0, 0, -1, -1, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_sample_source.md
Name: axis_sample_source

Overview:
- AXI4-Stream transmitter for the PL→AIE direction. Feeds a PL-to-AIE input port such as in_interpolator (pl2me) with framed 32-bit complex samples, {Q[31:16], I[15:0]}.
- Generates deterministic test patterns with correct TLAST framing, inter-frame gaps and full backpressure compliance.
- Used in simulation tops and hardware bring-up in place of an HLS producer kernel.

Parameters:
- LEN_W, 16, width of frame_len, num_frames and frame counters.
- GAP_W, 8, width of gap_cycles.
- LFSR_SEED, 32'h0000_0001, LFSR value loaded on each start; must be nonzero.

Ports:
- axis_aclk  in  1  stream clock
- axis_aresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- stop  in  1  pulse; finish current frame, then go to IDLE
- mode  in  2  0 ramp, 1 LFSR, 2 alternating full-scale, 3 reserved (behaves as 0)
- frame_len  in  LEN_W  beats per frame; 0 treated as 1
- num_frames  in  LEN_W  frames per run; 0 means continuous until stop
- gap_cycles  in  GAP_W  idle cycles (TVALID=0) between frames
- busy  out  1  high from start acceptance until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE
- frames_sent  out  LEN_W  completed frames this run; wraps modulo 2^LEN_W
- m_axis_tdata  out  32  sample
- m_axis_tvalid  out  1  valid
- m_axis_tready  in  1  ready from AIE
- m_axis_tkeep  out  4  constant 4'hF
- m_axis_tstrb  out  4  constant 4'hF
- m_axis_tlast  out  1  high on the last beat of each frame

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; tvalid=0, tlast=0, tdata=0, busy=0, done=0, frames_sent=0, beat and sample counters 0, LFSR=LFSR_SEED.
- Config latch: mode, frame_len, num_frames and gap_cycles are latched on start acceptance. Changes mid-run are ignored.
- start while busy: ignored.
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE→LOAD on start. busy rises the next cycle.
  - LOAD (one cycle): present the first beat. tvalid=1 in the cycle after LOAD (start-to-first-tvalid latency = 2 cycles).
  - SEND: a beat transfers when tvalid&&tready.
    - On transfer of a non-last beat: present the next sample the following cycle, with no bubble.
    - On transfer of the last beat (tlast=1): frames_sent increments.
    - Exit to IDLE if this was the final frame, or stop was seen. Otherwise go to GAP, or straight back to SEND with the next frame's first beat if gap_cycles=0.
  - GAP: tvalid=0 for exactly gap_cycles cycles, then SEND.
  - On reaching IDLE: done pulses for 1 cycle and busy falls in the same cycle.
- AXIS rule: once tvalid=1, tdata and tlast are held stable until the handshake. tvalid never drops without a handshake (reset excepted). tvalid does not depend on tready.
- tlast = (beat index == frame_len_eff−1). With frame_len_eff=1, every beat has tlast=1.
- stop:
  - Sticky until the current frame's tlast handshake.
  - In GAP: go to IDLE immediately.
  - In LOAD: the run completes its first frame.
  - stop coinciding with the final-frame tlast handshake: single done pulse.
- Sample index n counts beats across the whole run (not reset per frame), 16-bit wrap.
- Mode 0 (ramp): I=n[15:0], Q=(−n)[15:0] in two's complement. n=0 gives 0x0000_0000. n=1 gives 0xFFFF_0001.
- Mode 1 (LFSR): Fibonacci, taps 32,22,2,1. tdata = current LFSR state; advances once per handshake.
- Mode 2 (alternating): even n gives I=0x7FFF, Q=0x8001; odd n gives I=0x8001, Q=0x7FFF.
- Reset mid-transfer: tvalid drops asynchronously and the run is abandoned with no done pulse.

Test Plan:
- Ramp basic: mode=0, frame_len=4, num_frames=2, gap=0, tready=1. Expect 8 back-to-back beats with tdata 0x0000_0000, 0xFFFF_0001, 0xFFFE_0002, 0xFFFD_0003, … ; tlast on beats 3 and 7; frames_sent=2; done one cycle after the last handshake; first tvalid 2 cycles after start.
- Backpressure: same config, tready toggling 1010… and a 5-cycle low burst. Expect tdata/tlast stable while tvalid&&!tready, no lost or duplicated beats, same 8-value sequence.
- Gap and degenerate length: frame_len=0, gap=3, num_frames=3, mode=2. Expect 3 single-beat frames, each with tlast=1; data 0x8001_7FFF, 0x7FFF_8001, 0x8001_7FFF; exactly 3 tvalid-low cycles between frames.
- Continuous plus stop: num_frames=0, frame_len=16, stop pulsed at beat 20. Expect the run to end after beat 31 (tlast); frames_sent=2; single done pulse; start during busy ignored.
- LFSR: mode=1, frame_len=8, num_frames=1. First beat = 0x0000_0001; subsequent beats match the reference model for taps 32,22,2,1; no advance while stalled.
- Async reset mid-frame: assert axis_aresetn=0 at beat 5 of 8. Expect tvalid=0 without waiting for a clock edge; no done pulse; after release, a new start yields ramp data again from n=0.
